// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the pipelined control unit: opcode encodings, ALU-op codes,
// per-stage control bundles and the branch-condition helper.
package cpu_ctrl_pkg;

    localparam int ALU_BITS = 3;

    typedef enum logic [3:0] {
        OP_SUB  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LSL  = 4'b0010,
        OP_NEG  = 4'b0011,
        OP_BEQ  = 4'b0100,
        OP_BGT  = 4'b0101,
        OP_BLT  = 4'b0110,
        OP_B    = 4'b0111,
        OP_MOVI = 4'b1000,
        OP_LDR  = 4'b1001,
        OP_STR  = 4'b1010,
        OP_CMP  = 4'b1011,
        OP_MOVR = 4'b1100
    } opcode_e;

    localparam logic [ALU_BITS-1:0] ALU_SUB = 3'b000;
    localparam logic [ALU_BITS-1:0] ALU_ADD = 3'b001;
    localparam logic [ALU_BITS-1:0] ALU_LSL = 3'b010;
    localparam logic [ALU_BITS-1:0] ALU_NEG = 3'b011;
    localparam logic [ALU_BITS-1:0] ALU_STR = 3'b100;
    localparam logic [ALU_BITS-1:0] ALU_CMP = 3'b101;

    // Immediate-field select: register operand, move immediate, memory offset, shift amount.
    localparam logic [1:0] RI_REG   = 2'b00;
    localparam logic [1:0] RI_IMM   = 2'b01;
    localparam logic [1:0] RI_MEM   = 2'b10;
    localparam logic [1:0] RI_SHAMT = 2'b11;

    localparam logic [1:0] MM_NONE  = 2'b00;
    localparam logic [1:0] MM_LOAD  = 2'b01;
    localparam logic [1:0] MM_STORE = 2'b10;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_GT   = 3'd2,
        BR_LT   = 3'd3,
        BR_AL   = 3'd4
    } br_e;

    typedef struct packed {
        logic [ALU_BITS-1:0] alu_op;
        logic [1:0]          ri;
        logic                alu_mux;   // ALU B operand from immediate
        logic                am;        // ALU result is a memory address
    } ex_ctrl_t;

    // wce marks a flag-updating instruction (cmp); the flags load while it sits in EX.
    typedef struct packed {
        logic [1:0] mm;
        logic       wme1;   // data-memory write (store)
        logic       wme2;   // data-memory read (load)
        logic       wce;
    } mem_ctrl_t;

    // live distinguishes a real instruction (including branches/cmp/str) from a bubble.
    typedef struct packed {
        logic live;
        logic wbs;       // write-back data from memory
        logic wre;
        logic wm;        // write-back from a move
        logic reg_dest;  // destination taken from the immediate-format field
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ex_stage_t;

    typedef struct packed {
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } mem_stage_t;

    function automatic logic branch_taken(input br_e br, input logic n, input logic z);
        case (br)
            BR_EQ:   return z;
            BR_GT:   return !n;
            BR_LT:   return n;
            BR_AL:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decoder: opcode -> full EX/MEM/WB control bundle and branch kind.
// Unknown opcodes and an empty ID slot decode as an all-zero bubble.
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] i_opcode,
    input  logic           i_valid,
    output ex_stage_t      o_ctrl,
    output br_e            o_br
);

    logic [31:0] w_opx;
    logic        w_legal;

    // Wider opcode buses only carry legal codes when their upper bits are zero.
    assign w_opx   = 32'(i_opcode);
    assign w_legal = i_valid && (w_opx[31:4] == 28'd0);

    always_comb begin
        o_ctrl = '0;
        o_br   = BR_NONE;
        if (w_legal) begin
            case (opcode_e'(w_opx[3:0]))
                OP_SUB: begin
                    o_ctrl.ex.alu_op = ALU_SUB;
                    o_ctrl.wb.live   = 1'b1;
                    o_ctrl.wb.wre    = 1'b1;
                end
                OP_ADD: begin
                    o_ctrl.ex.alu_op = ALU_ADD;
                    o_ctrl.wb.live   = 1'b1;
                    o_ctrl.wb.wre    = 1'b1;
                end
                OP_LSL: begin
                    o_ctrl.ex.alu_op  = ALU_LSL;
                    o_ctrl.ex.ri      = RI_SHAMT;
                    o_ctrl.ex.alu_mux = 1'b1;
                    o_ctrl.wb.live    = 1'b1;
                    o_ctrl.wb.wre     = 1'b1;
                end
                OP_NEG: begin
                    o_ctrl.ex.alu_op = ALU_NEG;
                    o_ctrl.wb.live   = 1'b1;
                    o_ctrl.wb.wre    = 1'b1;
                end
                OP_BEQ: begin
                    o_ctrl.wb.live = 1'b1;
                    o_br           = BR_EQ;
                end
                OP_BGT: begin
                    o_ctrl.wb.live = 1'b1;
                    o_br           = BR_GT;
                end
                OP_BLT: begin
                    o_ctrl.wb.live = 1'b1;
                    o_br           = BR_LT;
                end
                OP_B: begin
                    o_ctrl.wb.live = 1'b1;
                    o_br           = BR_AL;
                end
                OP_MOVI: begin
                    o_ctrl.ex.ri       = RI_IMM;
                    o_ctrl.ex.alu_mux  = 1'b1;
                    o_ctrl.wb.live     = 1'b1;
                    o_ctrl.wb.wre      = 1'b1;
                    o_ctrl.wb.wm       = 1'b1;
                    o_ctrl.wb.reg_dest = 1'b1;
                end
                OP_LDR: begin
                    o_ctrl.ex.alu_op   = ALU_ADD;
                    o_ctrl.ex.ri       = RI_MEM;
                    o_ctrl.ex.alu_mux  = 1'b1;
                    o_ctrl.ex.am       = 1'b1;
                    o_ctrl.mem.mm      = MM_LOAD;
                    o_ctrl.mem.wme2    = 1'b1;
                    o_ctrl.wb.live     = 1'b1;
                    o_ctrl.wb.wbs      = 1'b1;
                    o_ctrl.wb.wre      = 1'b1;
                    o_ctrl.wb.reg_dest = 1'b1;
                end
                OP_STR: begin
                    o_ctrl.ex.alu_op  = ALU_STR;
                    o_ctrl.ex.ri      = RI_MEM;
                    o_ctrl.ex.alu_mux = 1'b1;
                    o_ctrl.ex.am      = 1'b1;
                    o_ctrl.mem.mm     = MM_STORE;
                    o_ctrl.mem.wme1   = 1'b1;
                    o_ctrl.wb.live    = 1'b1;
                end
                OP_CMP: begin
                    o_ctrl.ex.alu_op = ALU_CMP;
                    o_ctrl.mem.wce   = 1'b1;
                    o_ctrl.wb.live   = 1'b1;
                end
                OP_MOVR: begin
                    o_ctrl.wb.live = 1'b1;
                    o_ctrl.wb.wre  = 1'b1;
                    o_ctrl.wb.wm   = 1'b1;
                end
                default: begin
                    o_ctrl = '0;
                    o_br   = BR_NONE;
                end
            endcase
        end
    end

endmodule

// File: rtl/control_unit_pipe.sv
// Pipelined control unit: EX/MEM/WB control registers, architectural N/Z flags,
// branch resolution in ID with a one-cycle flush, and a retired-instruction counter.
module control_unit_pipe
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW   = 4,
    parameter int ALUW  = 3,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [OPW-1:0]   opcode,
    input  logic             stall,
    input  logic             alu_flag_n,
    input  logic             alu_flag_z,
    output logic [ALUW-1:0]  ex_alu_op,
    output logic [1:0]       ex_ri,
    output logic             ex_alu_mux,
    output logic             ex_am,
    output logic [1:0]       mem_mm,
    output logic             mem_wme1,
    output logic             mem_wme2,
    output logic             mem_wce,
    output logic             wb_wbs,
    output logic             wb_wre,
    output logic             wb_wm,
    output logic             wb_reg_dest,
    output logic             ni,
    output logic             flush,
    output logic             flag_n,
    output logic             flag_z,
    output logic [CNT_W-1:0] retired
);

    // Handshake: id_valid qualifies opcode for the current cycle; stall acts as
    // not-ready, so the ID instruction is not consumed and must be presented again,
    // while a bubble enters EX. flush kills the ID instruction outright.

    ex_stage_t        w_dec;
    br_e              w_br;
    ex_stage_t        w_ex_next;
    logic             w_ex_cmp;
    logic             w_n;
    logic             w_z;
    logic             w_taken;
    logic             w_ni;

    ex_stage_t        r_ex;
    mem_stage_t       r_mem;
    wb_ctrl_t         r_wb;
    logic             r_flush;
    logic             r_flag_n;
    logic             r_flag_z;
    logic [CNT_W-1:0] r_retired;

    ctrl_decode #(
        .OPW (OPW)
    ) u_decode (
        .i_opcode (opcode),
        .i_valid  (id_valid),
        .o_ctrl   (w_dec),
        .o_br     (w_br)
    );

    // A cmp in EX has not yet written the flags, so its live result is bypassed.
    assign w_ex_cmp = r_ex.mem.wce;
    assign w_n      = w_ex_cmp ? alu_flag_n : r_flag_n;
    assign w_z      = w_ex_cmp ? alu_flag_z : r_flag_z;
    assign w_taken  = branch_taken(w_br, w_n, w_z);
    assign w_ni     = rst_n && w_taken && !stall && !r_flush;

    assign w_ex_next = (r_flush || stall) ? '0 : w_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex      <= '0;
            r_mem     <= '0;
            r_wb      <= '0;
            r_flush   <= 1'b0;
            r_flag_n  <= 1'b0;
            r_flag_z  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_ex      <= w_ex_next;
            r_mem.mem <= r_ex.mem;
            r_mem.wb  <= r_ex.wb;
            r_wb      <= r_mem.wb;
            r_flush   <= w_ni;
            if (w_ex_cmp) begin
                r_flag_n <= alu_flag_n;
                r_flag_z <= alu_flag_z;
            end
            if (r_wb.live) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign ex_alu_op   = ALUW'(r_ex.ex.alu_op);
    assign ex_ri       = r_ex.ex.ri;
    assign ex_alu_mux  = r_ex.ex.alu_mux;
    assign ex_am       = r_ex.ex.am;
    assign mem_mm      = r_mem.mem.mm;
    assign mem_wme1    = r_mem.mem.wme1;
    assign mem_wme2    = r_mem.mem.wme2;
    assign mem_wce     = r_mem.mem.wce;
    assign wb_wbs      = r_wb.wbs;
    assign wb_wre      = r_wb.wre;
    assign wb_wm       = r_wb.wm;
    assign wb_reg_dest = r_wb.reg_dest;
    assign ni          = w_ni;
    assign flush       = r_flush;
    assign flag_n      = r_flag_n;
    assign flag_z      = r_flag_z;
    assign retired     = r_retired;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Scoreboard bench for control_unit_pipe: directed instruction vectors push their
// hand-computed stage controls with due cycles; a monitor pops and compares.
module tb_control_unit_pipe;

    localparam int CW = 4;

    // Entry layout: [38:36] kind, [35:20] due cycle, [19:0] expected value.
    localparam logic [2:0] K_NI  = 3'd0;
    localparam logic [2:0] K_FL  = 3'd1;
    localparam logic [2:0] K_EX  = 3'd2;
    localparam logic [2:0] K_MEM = 3'd3;
    localparam logic [2:0] K_WB  = 3'd4;
    localparam logic [2:0] K_RET = 3'd5;
    localparam logic [2:0] K_FLG = 3'd6;
    localparam logic [2:0] K_ALL = 3'd7;

    // Expected stage words: ex {alu_op,ri,alu_mux,am}, mem {mm,wme1,wme2,wce}, wb {wbs,wre,wm,reg_dest}.
    localparam logic [6:0] E_ADD  = 7'b001_00_0_0;
    localparam logic [6:0] E_SUB  = 7'b000_00_0_0;
    localparam logic [6:0] E_CMP  = 7'b101_00_0_0;
    localparam logic [6:0] E_LDR  = 7'b001_10_1_1;
    localparam logic [6:0] E_MOVR = 7'b000_00_0_0;
    localparam logic [6:0] E_NEG  = 7'b011_00_0_0;
    localparam logic [6:0] E_LSL  = 7'b010_11_1_0;
    localparam logic [4:0] M_0    = 5'b00_0_0_0;
    localparam logic [4:0] M_CMP  = 5'b00_0_0_1;
    localparam logic [4:0] M_LDR  = 5'b01_0_1_0;
    localparam logic [3:0] W_0    = 4'b0000;
    localparam logic [3:0] W_ALU  = 4'b0100;
    localparam logic [3:0] W_LDR  = 4'b1101;
    localparam logic [3:0] W_MOVR = 4'b0110;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [3:0]    opcode = 4'd0;
    logic          stall = 1'b0;
    logic          alu_flag_n = 1'b0;
    logic          alu_flag_z = 1'b0;
    logic [2:0]    ex_alu_op;
    logic [1:0]    ex_ri;
    logic          ex_alu_mux, ex_am;
    logic [1:0]    mem_mm;
    logic          mem_wme1, mem_wme2, mem_wce;
    logic          wb_wbs, wb_wre, wb_wm, wb_reg_dest;
    logic          ni, flush, flag_n, flag_z;
    logic [CW-1:0] retired;

    int            cyc;
    int            total;
    int            bad;
    bit            done;
    bit            reported;
    logic [38:0]   exp_q[$];

    control_unit_pipe #(
        .OPW   (4),
        .ALUW  (3),
        .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .opcode      (opcode),
        .stall       (stall),
        .alu_flag_n  (alu_flag_n),
        .alu_flag_z  (alu_flag_z),
        .ex_alu_op   (ex_alu_op),
        .ex_ri       (ex_ri),
        .ex_alu_mux  (ex_alu_mux),
        .ex_am       (ex_am),
        .mem_mm      (mem_mm),
        .mem_wme1    (mem_wme1),
        .mem_wme2    (mem_wme2),
        .mem_wce     (mem_wce),
        .wb_wbs      (wb_wbs),
        .wb_wre      (wb_wre),
        .wb_wm       (wb_wm),
        .wb_reg_dest (wb_reg_dest),
        .ni          (ni),
        .flush       (flush),
        .flag_n      (flag_n),
        .flag_z      (flag_z),
        .retired     (retired)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- driver tasks ----------------
    task automatic push(input logic [2:0] k, input int due, input logic [19:0] v);
        logic [15:0] d;
        d = due[15:0];
        exp_q.push_back({k, d, v});
    endtask

    task automatic issue(input bit chk, input logic v, input logic [3:0] op, input logic st,
                         input logic an, input logic az, input logic e_ni,
                         input logic [6:0] e_ex, input logic [4:0] e_mem, input logic [3:0] e_wb);
        int c;
        @(posedge clk);
        #1;
        c = cyc;
        id_valid   = v;
        opcode     = op;
        stall      = st;
        alu_flag_n = an;
        alu_flag_z = az;
        if (chk) begin
            push(K_NI,  c,     {19'd0, e_ni});
            push(K_FL,  c + 1, {19'd0, e_ni});
            push(K_EX,  c + 1, {13'd0, e_ex});
            push(K_MEM, c + 2, {15'd0, e_mem});
            push(K_WB,  c + 3, {16'd0, e_wb});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 5'd0, 4'd0);
    endtask

    task automatic expect_state(input logic [CW-1:0] ret, input logic fn, input logic fz);
        push(K_RET, cyc, {{(20-CW){1'b0}}, ret});
        push(K_FLG, cyc, {18'd0, fn, fz});
    endtask

    task automatic expect_reset_now();
        push(K_ALL, cyc, 20'd0);
        push(K_NI,  cyc, 20'd0);
        push(K_RET, cyc, 20'd0);
        push(K_FLG, cyc, 20'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    function automatic string kname(input logic [2:0] k);
        case (k)
            K_NI:    return "ni";
            K_FL:    return "flush";
            K_EX:    return "ex_ctrl";
            K_MEM:   return "mem_ctrl";
            K_WB:    return "wb_ctrl";
            K_RET:   return "retired";
            K_FLG:   return "flags";
            default: return "reset_outputs";
        endcase
    endfunction

    always begin : monitor
        logic [38:0] e;
        logic [19:0] got;
        @(negedge clk or negedge rst_n);
        #1;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            e = exp_q[i];
            if (e[35:20] == cyc[15:0]) begin
                case (e[38:36])
                    K_NI:    got = {19'd0, ni};
                    K_FL:    got = {19'd0, flush};
                    K_EX:    got = {13'd0, ex_alu_op, ex_ri, ex_alu_mux, ex_am};
                    K_MEM:   got = {15'd0, mem_mm, mem_wme1, mem_wme2, mem_wce};
                    K_WB:    got = {16'd0, wb_wbs, wb_wre, wb_wm, wb_reg_dest};
                    K_RET:   got = {{(20-CW){1'b0}}, retired};
                    K_FLG:   got = {18'd0, flag_n, flag_z};
                    default: got = {1'b0, ex_alu_op, ex_ri, ex_alu_mux, ex_am, mem_mm, mem_wme1,
                                    mem_wme2, mem_wce, wb_wbs, wb_wre, wb_wm, wb_reg_dest,
                                    flush, flag_n, flag_z};
                endcase
                total++;
                if (got !== e[19:0]) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%0h want=%0h", kname(e[38:36]), cyc, got, e[19:0]);
                end
                exp_q.delete(i);
            end
        end
        if (done && !reported) begin
            foreach (exp_q[j]) begin
                total++;
                bad++;
                $display("FAIL unchecked_%s due=%0d want=%0h", kname(exp_q[j][38:36]),
                         exp_q[j][35:20], exp_q[j][19:0]);
            end
            reported = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state, with a taken branch presented so ni must still read 0.
        repeat (2) @(posedge clk);
        #1;
        id_valid = 1'b1;
        opcode   = 4'b0111;
        expect_reset_now();
        @(negedge clk);
        #3;
        rst_n    = 1'b1;
        id_valid = 1'b0;

        //    chk  v     op       st    an    az    ni    ex      mem    wb
        issue(1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, E_ADD,  M_0,   W_ALU);  // add
        issue(1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, E_SUB,  M_0,   W_ALU);  // sub
        issue(1, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, E_CMP,  M_CMP, W_0);    // cmp
        issue(1, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0,   M_0,   W_0);    // beq via bypass
        issue(1, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0,   M_0,   W_0);    // movi flushed
        issue(1, 1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0,   M_0,   W_0);    // blt, N=0 stored
        issue(1, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0,   M_0,   W_0);    // ldr stalled
        issue(1, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0,   M_0,   W_0);    // ldr stalled
        issue(1, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, E_LDR,  M_LDR, W_LDR);  // ldr released
        issue(1, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0,   M_0,   W_0);    // bgt stalled
        issue(1, 1'b1, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b1, 7'd0,   M_0,   W_0);    // bgt taken, no bypass
        issue(1, 1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0,   M_0,   W_0);    // str flushed, stall too
        issue(1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0,   M_0,   W_0);    // illegal opcode
        issue(1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0,   M_0,   W_0);    // id_valid=0
        issue(1, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0,   M_0,   W_0);    // b
        issue(1, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0,   M_0,   W_0);    // cmp flushed
        issue(1, 1'b1, 4'b1100, 1'b0, 1'b1, 1'b1, 1'b0, E_MOVR, M_0,   W_MOVR); // movr
        issue(1, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, E_NEG,  M_0,   W_ALU);  // neg
        issue(1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, E_LSL,  M_0,   W_ALU);  // lsl
        idle(4);
        expect_state(4'd11, 1'b0, 1'b1);

        // Counter wrap: 11 + 5 = 16 -> 0, then 2 more.
        for (int i = 0; i < 5; i++) issue(1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, E_ADD, M_0, W_ALU);
        idle(4);
        expect_state(4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) issue(1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, E_SUB, M_0, W_ALU);
        idle(4);
        expect_state(4'd2, 1'b0, 1'b1);

        // Asynchronous reset with instructions in flight.
        issue(0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, M_0, W_0);
        issue(0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, M_0, W_0);
        issue(0, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0, M_0, W_0);
        #1;
        id_valid = 1'b1;
        opcode   = 4'b0111;
        expect_reset_now();
        rst_n = 1'b0;
        @(negedge clk);
        #3;
        rst_n    = 1'b1;
        id_valid = 1'b0;
        idle(4);
        expect_state(4'd0, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        done = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit_pipe.md
CONTROL_UNIT_PIPE -- requirements
Module: control_unit_pipe

Interface
REQ-001 The block SHALL provide parameter OPW, default 4, giving the opcode width.
REQ-002 The block SHALL provide parameter ALUW, default 3, giving the ALU operation width.
REQ-003 The block SHALL provide parameter CNT_W, default 32, giving the retired-instruction counter width.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 id_valid  in  1  instruction present in ID.
REQ-008 opcode  in  OPW  ID-stage opcode.
REQ-009 stall  in  1  hazard stall: hold ID, bubble into EX.
REQ-010 alu_flag_n, alu_flag_z  in  1 each  live EX-stage ALU negative/zero flags.
REQ-011 ex_alu_op  out  ALUW; ex_ri  out  2; ex_alu_mux, ex_am  out  1 each: EX-stage controls.
REQ-012 mem_mm  out  2; mem_wme1, mem_wme2, mem_wce  out  1 each: MEM-stage controls.
REQ-013 wb_wbs, wb_wre, wb_wm, wb_reg_dest  out  1 each: WB-stage controls.
REQ-014 ni  out  1  branch taken (combinational, ID); flush  out  1  kill ID instruction.
REQ-015 flag_n, flag_z  out  1 each  architectural flags; retired  out  CNT_W  retired-instruction count.

Function
REQ-016 The decoder SHALL use encodings 0000 sub, 0001 add, 0010 lsl, 0011 neg, 0100 beq, 0101 bgt, 0110 blt, 0111 b, 1000 movi, 1001 ldr, 1010 str, 1011 cmp, 1100 movr; all other codes and id_valid=0 decode as bubble (all controls 0).
REQ-017 ALU ops SHALL map sub 000, add 001, lsl 010, neg 011, str 100, cmp 101; every don't-care control SHALL drive 0, never X.
REQ-018 cmp SHALL have wre=0 and set flag-update; branches, str, cmp, bubble SHALL have wb_wre=0.
REQ-019 Controls for an instruction accepted in cycle n SHALL appear on ex_* in n+1, mem_* in n+2, wb_* in n+3.
REQ-020 flag_n/flag_z SHALL load alu_flag_n/alu_flag_z at the clock edge ending a cycle in which EX holds cmp; otherwise hold.
REQ-021 Branch conditions: beq taken when Z=1, bgt when N=0, blt when N=1, b always; N/Z SHALL be bypassed from alu_flag_* when EX holds cmp, else taken from flag_*.
REQ-022 ni SHALL be 1 only for a valid taken branch with stall=0 and flush=0.
REQ-023 flush SHALL be registered ni: asserted exactly one cycle after a taken branch; the ID instruction in that cycle SHALL enter EX as bubble and never update flags or counter.
REQ-024 flush SHALL take priority over stall; stall is ignored in a flush cycle.
REQ-025 stall=1 (no flush) SHALL insert a bubble into EX and suppress ni; MEM and WB SHALL advance normally.
REQ-026 retired SHALL increment by 1 each cycle WB holds a non-bubble instruction, wrapping 2^CNT_W-1 -> 0.

Reset
REQ-027 rst_n=0 SHALL immediately set all stage registers to bubble, flag_n=flag_z=0, flush=0, retired=0; ni SHALL read 0 during reset.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight instructions without counting them.

Structure
REQ-029 The opcode enum, ALU-op constants and the ex/mem/wb control structs SHALL live in package cpu_ctrl_pkg.
REQ-030 Combinational decode SHALL be a sub-module ctrl_decode (opcode, id_valid -> control struct); control_unit_pipe holds pipeline registers, flags, flush and counter.

Verification
REQ-031 add then sub, no stall -> ex_alu_op 001 at n+1, 000 at n+2; wb_wre=1 at n+3, n+4; retired=2 after n+4.
REQ-032 cmp with alu_flag_z=1 in EX while beq in ID -> ni=1 same cycle (bypass), flush=1 next cycle, flag_z=1 afterwards.
REQ-033 blt with flag_n=0 -> ni=0, flush stays 0, no bubble inserted.
REQ-034 stall=1 for 2 cycles with ldr in ID -> two bubbles on ex_*, ldr reaches ex_ri=10 after release; retired excludes bubbles.
REQ-035 opcode 1111, and id_valid=0 -> all stage outputs 0, no X, retired unchanged.
REQ-036 retired preloaded at 2^CNT_W-1 with valid WB instruction -> wraps to 0; rst_n pulse mid-pipeline -> all outputs 0 asynchronously.
